regfile_write_sched: RTL and testbench
======================================

# regfile_write_sched

Write-port scheduler and destination scoreboard for the 4 x 8-bit register file. It shares the register file's single write port between two writeback sources: port 0 for ALU results and port 1 for load/IO results. Arbitration is round-robin with valid/ready handshakes, and all register-file write controls are registered. A 4-bit busy scoreboard records destinations reserved by issued instructions, so the sequencer can stall on read-after-write and write-after-write hazards.

## Interface
Parameters:
- DATA_W, 8, width of write data (matches register file)
- ADDR_W, 2, register index width (4 registers)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- issue_valid  input  1  sequencer requests reservation of destination issue_rd
- issue_rd  input  2  destination register to reserve
- issue_ready  output  1  combinational; equals !busy[issue_rd]
- wb0_valid  input  1  ALU writeback request
- wb0_rd  input  2  ALU destination
- wb0_data  input  8  ALU result
- wb0_ready  output  1  combinational grant to port 0
- wb1_valid  input  1  load/IO writeback request
- wb1_rd  input  2  load/IO destination
- wb1_data  input  8  load/IO result
- wb1_ready  output  1  combinational grant to port 1
- rf_we  output  1  registered; drives register file RegWrite
- rf_rd  output  2  registered; drives register file rd
- rf_wdata  output  8  registered; drives register file writeData
- busy  output  4  registered scoreboard, one bit per register
- write_count  output  8  registered count of completed writes; wraps 255 -> 0

## Operation
- Issue: a reservation is accepted when issue_valid && issue_ready. At that clock edge, busy[issue_rd] is set. If issue_rd is already busy, issue_ready is 0, nothing changes, and the sequencer holds its request.
- Arbitration: at most one grant per cycle.
  - If only one port is valid, that port is granted.
  - If both ports are valid, the port that is not last_grant wins.
  - last_grant updates on every grant. Reset value is 1, so port 0 wins the first contention.
  - wbN_ready is 1 only in the cycle port N is granted. A transfer occurs when valid && ready.
- Requester rules: once valid is asserted, wbN_valid, wbN_rd and wbN_data must hold until the grant. A waiting port is never starved; it wins the next contended cycle.
- Write stage: a grant at edge N loads rf_we=1, rf_rd and rf_wdata from the granted port. Without a grant, rf_we is loaded with 0 and rf_rd/rf_wdata hold their values.
- Completion: in the cycle rf_we=1, at the following edge:
  - busy[rf_rd] clears (a no-op if that register was not reserved);
  - write_count increments modulo 256.
- Unreserved writebacks, to a register whose busy bit is 0, are legal and are written normally.
- Same-edge set/clear:
  - If issue accepts rd=r and a completion clears rd=r at the same edge, the set wins and busy[r] stays 1.
  - This case is only reachable when the completion targets r while busy[r]=0 (an unreserved write). Otherwise issue_ready is 0 for r.
- Both ports naming the same rd in the same cycle: the ports are serialised by round-robin. The later grant's data is the final register value.

## Timing
- Reset values: rf_we=0, rf_rd=0, rf_wdata=0, busy=4'b0000, write_count=0, last_grant=1.
- Reset is asynchronous. Asserting it mid-operation drops any pending write immediately: rf_we goes to 0 without waiting for a clock edge. The scoreboard also clears, and requesters must re-present their requests after reset.
- Grant to register-file write: grant in cycle N, rf_we=1 during cycle N+1, register file updated at the end of N+1. busy clears at that same edge.
- Throughput: one write per cycle sustained. Back-to-back grants produce rf_we=1 on consecutive cycles.
- issue_ready, wb0_ready and wb1_ready are combinational from the current state and current inputs. There is no combinational path from issue_* to wb*_ready.

## Test plan
- Reset, then idle for 3 cycles: rf_we=0, busy=0000, write_count=0, and both readys are 0.
- Issue rd=2 (busy becomes 0100), then wb0 {rd=2, data=0x5A}: wb0_ready=1 in the same cycle; next cycle rf_we=1, rf_rd=2, rf_wdata=0x5A; at the following edge busy=0000 and write_count=1.
- Hold wb0 and wb1 valid for 4 cycles with rd=1/3 and data=0x11/0x33: grants alternate 0,1,0,1; the rf_we stream is continuous and write_count reaches 4.
- Issue rd=1 twice on consecutive cycles: the second attempt sees issue_ready=0 until the write to rd=1 completes, then is accepted on the cycle after busy[1] clears.
- Issue rd=0 in the same cycle that an unreserved write to rd=0 is in its rf_we cycle: busy[0]=1 afterwards.
- Assert reset during a cycle with rf_we=1 and busy=1010: rf_we drops immediately and busy=0000. Drive 256 writes afterwards: write_count wraps to 0.

Source files
------------

// File: rtl/regfile_write_sched.sv
// Write-port scheduler and destination scoreboard for the register file.
// Round-robin shares the single write port between ALU and load/IO writeback.
module regfile_write_sched #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_rd,
    output logic                     issue_ready,
    input  logic                     wb0_valid,
    input  logic [ADDR_W-1:0]        wb0_rd,
    input  logic [DATA_W-1:0]        wb0_data,
    output logic                     wb0_ready,
    input  logic                     wb1_valid,
    input  logic [ADDR_W-1:0]        wb1_rd,
    input  logic [DATA_W-1:0]        wb1_data,
    output logic                     wb1_ready,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_rd,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic [(1<<ADDR_W)-1:0]   busy,
    output logic [7:0]               write_count
);

    localparam int NREG = 1 << ADDR_W;

    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0]     busy_q, busy_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                last_q, last_d;
    logic                gnt0, gnt1;

    // Contention goes to whichever port did not win last time.
    assign gnt0 = wb0_valid && (!wb1_valid || last_q);
    assign gnt1 = wb1_valid && (!wb0_valid || !last_q);

    assign wb0_ready   = gnt0;
    assign wb1_ready   = gnt1;
    assign issue_ready = !busy_q[issue_rd];

    always_comb begin
        rf_we_d    = gnt0 || gnt1;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        last_d     = last_q;
        unique case (1'b1)
            gnt0: begin
                rf_rd_d    = wb0_rd;
                rf_wdata_d = wb0_data;
                last_d     = 1'b0;
            end
            gnt1: begin
                rf_rd_d    = wb1_rd;
                rf_wdata_d = wb1_data;
                last_d     = 1'b1;
            end
            default: ;
        endcase
    end

    // Clear before set so a same-edge reservation of the written reg wins.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (rf_we_q) begin
            busy_d[rf_rd_q] = 1'b0;
            cnt_d           = cnt_q + 8'd1;
        end
        if (issue_valid && issue_ready) begin
            busy_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b1;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_rd       = rf_rd_q;
    assign rf_wdata    = rf_wdata_q;
    assign busy        = busy_q;
    assign write_count = cnt_q;

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed bench for regfile_write_sched.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_regfile_write_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic [1:0] issue_rd;
    logic       issue_ready;
    logic       wb0_valid;
    logic [1:0] wb0_rd;
    logic [7:0] wb0_data;
    logic       wb0_ready;
    logic       wb1_valid;
    logic [1:0] wb1_rd;
    logic [7:0] wb1_data;
    logic       wb1_ready;
    logic       rf_we;
    logic [1:0] rf_rd;
    logic [7:0] rf_wdata;
    logic [3:0] busy;
    logic [7:0] write_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_write_sched #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_ready(issue_ready),
        .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
        .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
        .wb1_ready(wb1_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .busy(busy), .write_count(write_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        issue_valid = 0; issue_rd = 0;
        wb0_valid = 0; wb0_rd = 0; wb0_data = 0;
        wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
        step();
        step();
        reset = 1'b0;
        repeat (3) step();
        checks += 5;
        if (rf_we !== 1'b0) begin
            failures++; $display("FAIL reset_rf_we got=%b exp=0", rf_we);
        end
        if (busy !== 4'b0000) begin
            failures++; $display("FAIL reset_busy got=%b exp=0000", busy);
        end
        if (write_count !== 8'd0) begin
            failures++; $display("FAIL reset_count got=%0d exp=0", write_count);
        end
        if (wb0_ready !== 1'b0) begin
            failures++; $display("FAIL reset_wb0_ready got=%b exp=0", wb0_ready);
        end
        if (wb1_ready !== 1'b0) begin
            failures++; $display("FAIL reset_wb1_ready got=%b exp=0", wb1_ready);
        end
    endtask

    task automatic test_single_write();
        issue_valid = 1; issue_rd = 2;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            failures++; $display("FAIL single_issue_ready got=%b exp=1", issue_ready);
        end
        step();
        issue_valid = 0;
        checks++;
        if (busy !== 4'b0100) begin
            failures++; $display("FAIL single_busy_set got=%b exp=0100", busy);
        end
        wb0_valid = 1; wb0_rd = 2; wb0_data = 8'h5A;
        #1;
        checks += 2;
        if (wb0_ready !== 1'b1) begin
            failures++; $display("FAIL single_wb0_ready got=%b exp=1", wb0_ready);
        end
        if (wb1_ready !== 1'b0) begin
            failures++; $display("FAIL single_wb1_ready got=%b exp=0", wb1_ready);
        end
        step();
        wb0_valid = 0;
        checks += 4;
        if (rf_we !== 1'b1) begin
            failures++; $display("FAIL single_rf_we got=%b exp=1", rf_we);
        end
        if (rf_rd !== 2'd2) begin
            failures++; $display("FAIL single_rf_rd got=%0d exp=2", rf_rd);
        end
        if (rf_wdata !== 8'h5A) begin
            failures++; $display("FAIL single_rf_wdata got=%h exp=5a", rf_wdata);
        end
        if (busy !== 4'b0100) begin
            failures++; $display("FAIL single_busy_hold got=%b exp=0100", busy);
        end
        step();
        checks += 3;
        if (busy !== 4'b0000) begin
            failures++; $display("FAIL single_busy_clr got=%b exp=0000", busy);
        end
        if (write_count !== 8'd1) begin
            failures++; $display("FAIL single_count got=%0d exp=1", write_count);
        end
        if (rf_we !== 1'b0) begin
            failures++; $display("FAIL single_rf_we_off got=%b exp=0", rf_we);
        end
    endtask

    task automatic test_back_to_back();
        logic       e0;
        logic [1:0] erd;
        logic [7:0] edat;
        pulse_reset();
        wb0_valid = 1; wb0_rd = 1; wb0_data = 8'h11;
        wb1_valid = 1; wb1_rd = 3; wb1_data = 8'h33;
        for (int i = 0; i < 4; i++) begin
            e0 = (i % 2 == 0);
            #1;
            checks += 2;
            if (wb0_ready !== e0) begin
                failures++; $display("FAIL b2b_wb0_ready[%0d] got=%b exp=%b", i, wb0_ready, e0);
            end
            if (wb1_ready !== !e0) begin
                failures++; $display("FAIL b2b_wb1_ready[%0d] got=%b exp=%b", i, wb1_ready, !e0);
            end
            step();
            erd  = e0 ? 2'd1 : 2'd3;
            edat = e0 ? 8'h11 : 8'h33;
            checks += 3;
            if (rf_we !== 1'b1) begin
                failures++; $display("FAIL b2b_rf_we[%0d] got=%b exp=1", i, rf_we);
            end
            if (rf_rd !== erd) begin
                failures++; $display("FAIL b2b_rf_rd[%0d] got=%0d exp=%0d", i, rf_rd, erd);
            end
            if (rf_wdata !== edat) begin
                failures++; $display("FAIL b2b_rf_wdata[%0d] got=%h exp=%h", i, rf_wdata, edat);
            end
        end
        wb0_valid = 0; wb1_valid = 0;
        step();
        checks += 3;
        if (write_count !== 8'd4) begin
            failures++; $display("FAIL b2b_count got=%0d exp=4", write_count);
        end
        if (rf_we !== 1'b0) begin
            failures++; $display("FAIL b2b_rf_we_off got=%b exp=0", rf_we);
        end
        if (busy !== 4'b0000) begin
            failures++; $display("FAIL b2b_busy got=%b exp=0000", busy);
        end
    endtask

    task automatic test_issue_hazard();
        issue_valid = 1; issue_rd = 1;
        step();
        checks += 2;
        if (busy !== 4'b0010) begin
            failures++; $display("FAIL haz_busy_set got=%b exp=0010", busy);
        end
        if (issue_ready !== 1'b0) begin
            failures++; $display("FAIL haz_blocked0 got=%b exp=0", issue_ready);
        end
        wb0_valid = 1; wb0_rd = 1; wb0_data = 8'h77;
        step();
        wb0_valid = 0;
        checks += 3;
        if (rf_we !== 1'b1 || rf_rd !== 2'd1) begin
            failures++; $display("FAIL haz_write got=%b/%0d exp=1/1", rf_we, rf_rd);
        end
        if (issue_ready !== 1'b0) begin
            failures++; $display("FAIL haz_blocked1 got=%b exp=0", issue_ready);
        end
        if (busy !== 4'b0010) begin
            failures++; $display("FAIL haz_busy_hold got=%b exp=0010", busy);
        end
        step();
        checks += 2;
        if (busy !== 4'b0000) begin
            failures++; $display("FAIL haz_busy_clr got=%b exp=0000", busy);
        end
        if (issue_ready !== 1'b1) begin
            failures++; $display("FAIL haz_ready got=%b exp=1", issue_ready);
        end
        step();
        issue_valid = 0;
        checks += 2;
        if (busy !== 4'b0010) begin
            failures++; $display("FAIL haz_reissue got=%b exp=0010", busy);
        end
        if (write_count !== 8'd5) begin
            failures++; $display("FAIL haz_count got=%0d exp=5", write_count);
        end
    endtask

    task automatic test_same_edge();
        wb1_valid = 1; wb1_rd = 0; wb1_data = 8'h42;
        #1;
        checks++;
        if (wb1_ready !== 1'b1) begin
            failures++; $display("FAIL same_wb1_ready got=%b exp=1", wb1_ready);
        end
        step();
        wb1_valid = 0;
        issue_valid = 1; issue_rd = 0;
        #1;
        checks += 2;
        if (rf_we !== 1'b1 || rf_rd !== 2'd0 || rf_wdata !== 8'h42) begin
            failures++; $display("FAIL same_write got=%b/%0d/%h exp=1/0/42", rf_we, rf_rd, rf_wdata);
        end
        if (issue_ready !== 1'b1) begin
            failures++; $display("FAIL same_issue_ready got=%b exp=1", issue_ready);
        end
        step();
        issue_valid = 0;
        checks += 2;
        if (busy !== 4'b0011) begin
            failures++; $display("FAIL same_busy got=%b exp=0011", busy);
        end
        if (write_count !== 8'd6) begin
            failures++; $display("FAIL same_count got=%0d exp=6", write_count);
        end
    endtask

    task automatic test_async_reset_wrap();
        pulse_reset();
        issue_valid = 1; issue_rd = 1;
        step();
        issue_rd = 3;
        wb0_valid = 1; wb0_rd = 0; wb0_data = 8'h99;
        step();
        issue_valid = 0; wb0_valid = 0;
        checks += 2;
        if (rf_we !== 1'b1) begin
            failures++; $display("FAIL rst_pre_we got=%b exp=1", rf_we);
        end
        if (busy !== 4'b1010) begin
            failures++; $display("FAIL rst_pre_busy got=%b exp=1010", busy);
        end
        #2;
        reset = 1'b1;
        #1;
        checks += 3;
        if (rf_we !== 1'b0) begin
            failures++; $display("FAIL rst_async_we got=%b exp=0", rf_we);
        end
        if (busy !== 4'b0000) begin
            failures++; $display("FAIL rst_async_busy got=%b exp=0000", busy);
        end
        if (write_count !== 8'd0) begin
            failures++; $display("FAIL rst_async_count got=%0d exp=0", write_count);
        end
        step();
        reset = 1'b0;
        wb0_valid = 1; wb0_rd = 2; wb0_data = 8'hA5;
        repeat (256) step();
        wb0_valid = 0;
        checks++;
        if (write_count !== 8'd255) begin
            failures++; $display("FAIL wrap_255 got=%0d exp=255", write_count);
        end
        step();
        checks += 2;
        if (write_count !== 8'd0) begin
            failures++; $display("FAIL wrap_0 got=%0d exp=0", write_count);
        end
        if (rf_we !== 1'b0) begin
            failures++; $display("FAIL wrap_we_off got=%b exp=0", rf_we);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_issue_hazard();
        test_same_edge();
        test_async_reset_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
